multi_chan_fifo: RTL and testbench

MULTI_CHAN_FIFO -- requirements
Module: multi_chan_fifo

---
 rtl/multi_chan_fifo_pkg.sv | 22 ++
 rtl/multi_chan_fifo_chan.sv | 100 ++++++++++
 rtl/multi_chan_fifo.sv | 72 +++++++
 tb/tb_multi_chan_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_chan_fifo_pkg.sv
// Shared width helpers for the multi-channel FIFO.
// Everything here is constant-folded at elaboration.
package multi_chan_fifo_pkg;

    // Never returns 0, so a one-entry FIFO or a single channel still gets a 1-bit field.
    function automatic int safeClog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int calcChanWidth(input int numChannels);
        return (numChannels == 1) ? 1 : safeClog2(numChannels);
    endfunction

    function automatic int calcCountWidth(input int fifoDepth);
        return safeClog2(fifoDepth + 1);
    endfunction

    function automatic int calcPtrWidth(input int fifoDepth);
        return safeClog2(fifoDepth);
    endfunction

endpackage

// File: rtl/multi_chan_fifo_chan.sv
// One first-word-fall-through channel.
// Storage entries sit behind a registered output word.
module fifo_chan
    import multi_chan_fifo_pkg::*;
#(
    parameter int DataWidth        = 32,
    parameter int FifoDepth        = 3,
    parameter int AlmostFullThresh = FifoDepth - 1,
    localparam int CountWidth      = calcCountWidth(FifoDepth),
    localparam int PtrWidth        = calcPtrWidth(FifoDepth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pushAccept_i,
    input  logic                  flush_i,
    input  logic                  deq_i,
    input  logic [DataWidth-1:0]  dataIn_i,
    output logic                  dataValid_o,
    output logic [DataWidth-1:0]  dataOut_o,
    output logic                  full_o,
    output logic                  almostFull_o,
    output logic [CountWidth-1:0] count_o
);

    logic [DataWidth-1:0]  storage [FifoDepth];
    logic [PtrWidth-1:0]   headQ, headD, tailQ, tailD;
    logic [CountWidth-1:0] countQ, countD;
    logic                  validQ, validD;
    logic [DataWidth-1:0]  dataOutQ, dataOutD;
    logic                  loadOut, bypass, move, store;

    // Depth need not be a power of two, so wrap by compare.
    function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(FifoDepth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        loadOut  = !validQ || deq_i;
        bypass   = pushAccept_i && (countQ == '0) && loadOut;
        move     = (countQ != '0) && loadOut;
        store    = pushAccept_i && !bypass;
        headD    = headQ;
        tailD    = tailQ;
        countD   = countQ;
        validD   = validQ;
        dataOutD = dataOutQ;

        if (flush_i) begin
            headD  = '0;
            tailD  = '0;
            countD = '0;
            validD = 1'b0;
        end else begin
            if (bypass) begin
                dataOutD = dataIn_i;
                validD   = 1'b1;
            end else if (move) begin
                dataOutD = storage[tailQ];
                validD   = 1'b1;
                tailD    = nextPtr(tailQ);
            end else if (deq_i) begin
                validD = 1'b0;
            end
            if (store) begin
                headD = nextPtr(headQ);
            end
            countD = countQ + CountWidth'(store) - CountWidth'(move);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headQ    <= '0;
            tailQ    <= '0;
            countQ   <= '0;
            validQ   <= 1'b0;
            dataOutQ <= '0;
        end else begin
            headQ    <= headD;
            tailQ    <= tailD;
            countQ   <= countD;
            validQ   <= validD;
            dataOutQ <= dataOutD;
        end
    end

    // Storage is deliberately left out of reset; pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && store) begin
            storage[headQ] <= dataIn_i;
        end
    end

    assign dataValid_o  = validQ;
    assign dataOut_o    = dataOutQ;
    assign count_o      = countQ;
    assign full_o       = (countQ == CountWidth'(FifoDepth));
    assign almostFull_o = (int'(countQ) >= AlmostFullThresh);

endmodule

// File: rtl/multi_chan_fifo.sv
// Multi-channel FIFO top: push decode, drop flag, and one fifo_chan per channel.
// The push path is shared; the pop, flush and status signals are per channel.
module multi_chan_fifo
    import multi_chan_fifo_pkg::*;
#(
    parameter int DataWidth        = 32,
    parameter int FifoDepth        = 3,
    parameter int NumChannels      = 4,
    parameter int AlmostFullThresh = FifoDepth - 1,
    localparam int ChanWidth       = calcChanWidth(NumChannels),
    localparam int CountWidth      = calcCountWidth(FifoDepth)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              Push,
    input  logic [ChanWidth-1:0]              PushChan,
    input  logic [DataWidth-1:0]              DataIn,
    output logic                              PushDropped,
    input  logic [NumChannels-1:0]            Flush,
    input  logic [NumChannels-1:0]            Deq,
    output logic [NumChannels-1:0]            DataValid,
    output logic [NumChannels*DataWidth-1:0]  DataOut,
    output logic [NumChannels-1:0]            FifoFull,
    output logic [NumChannels-1:0]            AlmostFull,
    output logic [NumChannels*CountWidth-1:0] Count
);

    logic [NumChannels-1:0] pushAccept;
    logic                   pushDroppedQ, pushDroppedD;

    // An out-of-range PushChan matches no channel and so falls out as a drop.
    always_comb begin
        pushAccept = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (Push && (PushChan == ChanWidth'(c)) && !FifoFull[c] && !Flush[c]) begin
                pushAccept[c] = 1'b1;
            end
        end
        pushDroppedD = Push && (pushAccept == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pushDroppedQ <= 1'b0;
        end else begin
            pushDroppedQ <= pushDroppedD;
        end
    end

    assign PushDropped = pushDroppedQ;

    for (genvar c = 0; c < NumChannels; c++) begin : gChan
        fifo_chan #(
            .DataWidth        (DataWidth),
            .FifoDepth        (FifoDepth),
            .AlmostFullThresh (AlmostFullThresh)
        ) uChan (
            .clk          (clk),
            .rst          (rst),
            .pushAccept_i (pushAccept[c]),
            .flush_i      (Flush[c]),
            .deq_i        (Deq[c]),
            .dataIn_i     (DataIn),
            .dataValid_o  (DataValid[c]),
            .dataOut_o    (DataOut[c*DataWidth +: DataWidth]),
            .full_o       (FifoFull[c]),
            .almostFull_o (AlmostFull[c]),
            .count_o      (Count[c*CountWidth +: CountWidth])
        );
    end

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Directed bench for multi_chan_fifo with a per-channel scoreboard of expected words.
// A second small instance covers the out-of-range channel number.
module tb_multi_chan_fifo;

    localparam int DW    = 32;
    localparam int Depth = 3;
    localparam int NCh   = 4;
    localparam int CW    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            push;
    logic [1:0]      pushChan;
    logic [DW-1:0]   dataIn;
    logic            pushDropped;
    logic [NCh-1:0]  flush, deq, dataValid, fifoFull, almostFull;
    logic [NCh*DW-1:0] dataOut;
    logic [NCh*CW-1:0] count;

    logic        smallPush;
    logic [1:0]  smallChan;
    logic [7:0]  smallDin;
    logic [2:0]  smallFlush, smallDeq, smallValid, smallFull, smallAlmost;
    logic        smallDropped;
    logic [23:0] smallData;
    logic [5:0]  smallCount;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mq [NCh][$];

    always #5 clk = ~clk;

    multi_chan_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .Push        (push),
        .PushChan    (pushChan),
        .DataIn      (dataIn),
        .PushDropped (pushDropped),
        .Flush       (flush),
        .Deq         (deq),
        .DataValid   (dataValid),
        .DataOut     (dataOut),
        .FifoFull    (fifoFull),
        .AlmostFull  (almostFull),
        .Count       (count)
    );

    multi_chan_fifo #(
        .DataWidth   (8),
        .FifoDepth   (2),
        .NumChannels (3)
    ) dutSmall (
        .clk         (clk),
        .rst         (rst),
        .Push        (smallPush),
        .PushChan    (smallChan),
        .DataIn      (smallDin),
        .PushDropped (smallDropped),
        .Flush       (smallFlush),
        .Deq         (smallDeq),
        .DataValid   (smallValid),
        .DataOut     (smallData),
        .FifoFull    (smallFull),
        .AlmostFull  (smallAlmost),
        .Count       (smallCount)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected status is derived from the scoreboard: head word in the output register, rest in storage.
    task automatic checkOutput();
        for (int c = 0; c < NCh; c++) begin
            int sz;
            int expCount;
            sz = mq[c].size();
            expCount = (sz > 0) ? sz - 1 : 0;
            check($sformatf("valid%0d", c), 64'(dataValid[c]), 64'(sz > 0));
            check($sformatf("count%0d", c), 64'(count[c*CW +: CW]), 64'(expCount));
            check($sformatf("full%0d", c), 64'(fifoFull[c]), 64'(expCount == Depth));
            check($sformatf("almost%0d", c), 64'(almostFull[c]), 64'(expCount >= Depth - 1));
            if (sz > 0) begin
                check($sformatf("data%0d", c), 64'(dataOut[c*DW +: DW]), 64'(mq[c][0]));
            end
        end
    endtask

    task automatic applyStimulus(input logic p, input int chan, input logic [DW-1:0] din,
                                 input logic [NCh-1:0] dq, input logic [NCh-1:0] fl);
        logic accept;
        push     = p;
        pushChan = chan[1:0];
        dataIn   = din;
        deq      = dq;
        flush    = fl;
        accept   = p && (chan < NCh) && !fl[chan] && (mq[chan].size() < Depth + 1);
        for (int c = 0; c < NCh; c++) begin
            if (fl[c]) begin
                mq[c].delete();
            end else if (dq[c] && mq[c].size() > 0) begin
                void'(mq[c].pop_front());
            end
        end
        if (accept) begin
            mq[chan].push_back(din);
        end
        @(posedge clk);
        #1;
        push  = 1'b0;
        deq   = '0;
        flush = '0;
        check("pushDropped", 64'(pushDropped), 64'(p && !accept));
        checkOutput();
    endtask

    task automatic checkResetState();
        check("rstDropped", 64'(pushDropped), 64'd0);
        check("rstSmallValid", 64'(smallValid), 64'd0);
        check("rstSmallData", 64'(smallData), 64'd0);
        for (int c = 0; c < NCh; c++) begin
            check($sformatf("rstData%0d", c), 64'(dataOut[c*DW +: DW]), 64'd0);
        end
        checkOutput();
    endtask

    initial begin
        rst        = 1'b1;
        push       = 1'b0;
        pushChan   = '0;
        dataIn     = '0;
        flush      = '0;
        deq        = '0;
        smallPush  = 1'b0;
        smallChan  = '0;
        smallDin   = '0;
        smallFlush = '0;
        smallDeq   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState();

        applyStimulus(1'b1, 0, 32'hA1, '0, '0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1, 32'hB0 + i, '0, '0);
        end
        applyStimulus(1'b0, 0, 32'h0, '0, '0);
        applyStimulus(1'b1, 1, 32'hBF, 4'b0010, '0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2, 32'hC0 + i, '0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2, 32'hC3 + i, 4'b0100, '0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 0, 32'h0, 4'b0100, '0);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3, 32'hD0 + i, '0, '0);
        end
        applyStimulus(1'b1, 3, 32'hDF, 4'b1000, 4'b1000);

        smallPush = 1'b1;
        smallChan = 2'd3;
        smallDin  = 8'h55;
        @(posedge clk);
        #1;
        check("smallOorDrop", 64'(smallDropped), 64'd1);
        check("smallOorValid", 64'(smallValid), 64'd0);
        check("smallOorCount", 64'(smallCount), 64'd0);
        smallChan = 2'd2;
        smallDin  = 8'h66;
        @(posedge clk);
        #1;
        smallPush = 1'b0;
        check("smallDrop", 64'(smallDropped), 64'd0);
        check("smallValid", 64'(smallValid), 64'b100);
        check("smallData2", 64'(smallData[23:16]), 64'h66);

        applyStimulus(1'b1, 0, 32'hE0, '0, '0);
        applyStimulus(1'b1, 1, 32'hE1, '0, '0);
        rst      = 1'b1;
        push     = 1'b1;
        pushChan = 2'd0;
        dataIn   = 32'hEE;
        deq      = '1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        deq  = '0;
        for (int c = 0; c < NCh; c++) begin
            mq[c].delete();
        end
        checkResetState();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
